atm_message_tx: RTL and testbench

Output-side counterpart to the keypad/terminal input parser: converts a status code, an optional currency tag and a 4-digit BCD value into an ASCII byte stream for the user terminal (UART transmitter or character display). It sits between the ATM control FSM, which issues one `start` per message, and the byte sink, which consumes characters over a valid/ready handshake. It uses the same 4-bit status encoding, 3-bit currency encoding and 16-bit BCD packing as the input path, with the first-entered digit in `[3:0]`.

---
 rtl/atm_pkg.sv | 37 +++
 rtl/msg_char_rom.sv | 71 +++++++
 rtl/atm_message_tx.sv | 147 ++++++++++++++
 tb/tb_atm_message_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared encodings for the ATM terminal paths: status codes, currency codes,
// ASCII constants and the message transmitter state enum.
package atm_pkg;

    localparam logic [3:0] MSG_ACC_FOUND      = 4'd1;
    localparam logic [3:0] MSG_ACC_NOT_FOUND  = 4'd2;
    localparam logic [3:0] MSG_PIN_CORRECT    = 4'd3;
    localparam logic [3:0] MSG_PIN_INCORRECT  = 4'd4;
    localparam logic [3:0] MSG_AMT_VALID      = 4'd5;
    localparam logic [3:0] MSG_AMT_INVALID    = 4'd6;
    localparam logic [3:0] MSG_EXIT           = 4'd7;
    localparam logic [3:0] MSG_INPUT_COMPLETE = 4'd8;

    localparam logic [2:0] CUR_USD = 3'd0;
    localparam logic [2:0] CUR_BTC = 3'd1;
    localparam logic [2:0] CUR_ETH = 3'd2;
    localparam logic [2:0] CUR_XRP = 3'd3;
    localparam logic [2:0] CUR_LTC = 3'd4;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFIX,
        ST_SEP1,
        ST_CUR,
        ST_SEP2,
        ST_DIGITS,
        ST_CR,
        ST_LF
    } tx_state_e;

endpackage

// File: rtl/msg_char_rom.sv
// Combinational character table: maps the transmitter position and the
// latched message fields to the ASCII byte shown at that position.
module msg_char_rom
    import atm_pkg::*;
(
    input  tx_state_e   state,
    input  logic [1:0]  idx,
    input  logic [3:0]  code,
    input  logic [2:0]  currency,
    input  logic [3:0]  nibble,
    output logic [7:0]  char_out
);

    logic [31:0] prefix;
    logic [23:0] tag;

    always_comb begin
        prefix = "ERR?";
        case (code)
            MSG_ACC_FOUND:      prefix = "ACOK";
            MSG_ACC_NOT_FOUND:  prefix = "ACNF";
            MSG_PIN_CORRECT:    prefix = "PNOK";
            MSG_PIN_INCORRECT:  prefix = "PNBD";
            MSG_AMT_VALID:      prefix = "AMOK";
            MSG_AMT_INVALID:    prefix = "AMBD";
            MSG_EXIT:           prefix = "EXIT";
            MSG_INPUT_COMPLETE: prefix = "DONE";
            default:            prefix = "ERR?";
        endcase
    end

    always_comb begin
        tag = "???";
        case (currency)
            CUR_USD: tag = "USD";
            CUR_BTC: tag = "BTC";
            CUR_ETH: tag = "ETH";
            CUR_XRP: tag = "XRP";
            CUR_LTC: tag = "LTC";
            default: tag = "???";
        endcase
    end

    always_comb begin
        char_out = 8'h00;
        case (state)
            ST_PREFIX: begin
                case (idx)
                    2'd0:    char_out = prefix[31:24];
                    2'd1:    char_out = prefix[23:16];
                    2'd2:    char_out = prefix[15:8];
                    default: char_out = prefix[7:0];
                endcase
            end
            ST_SEP1, ST_SEP2: char_out = ASCII_SPACE;
            ST_CUR: begin
                case (idx)
                    2'd0:    char_out = tag[23:16];
                    2'd1:    char_out = tag[15:8];
                    default: char_out = tag[7:0];
                endcase
            end
            // Non-decimal nibbles are shown as '?' rather than as hex letters
            ST_DIGITS: char_out = (nibble <= 4'd9) ? (ASCII_ZERO + {4'h0, nibble}) : ASCII_QMARK;
            ST_CR:     char_out = ASCII_CR;
            ST_LF:     char_out = ASCII_LF;
            default:   char_out = 8'h00;
        endcase
    end

endmodule

// File: rtl/atm_message_tx.sv
// Message transmitter: turns a status code, optional currency tag and 4-digit
// BCD value into an ASCII byte stream over a valid/ready handshake.
module atm_message_tx
    import atm_pkg::*;
#(
    parameter bit EOL_LF = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  msg_code,
    input  logic        show_value,
    input  logic [2:0]  currency,
    input  logic [15:0] value,
    input  logic        abort,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    // A byte moves on any edge where tx_valid & tx_ready; tx_data is held
    // while tx_valid is high and the sink stalls.
    tx_state_e   state, nxt_state;
    logic [1:0]  idx, nxt_idx;
    logic [3:0]  code_q;
    logic        show_q;
    logic [2:0]  cur_q;
    logic [15:0] val_q;

    logic [3:0]  code_sel;
    logic [2:0]  cur_sel;
    logic [15:0] val_sel;
    logic [3:0]  nibble_sel;
    logic [7:0]  rom_byte;
    logic        xfer;

    assign xfer = tx_valid & tx_ready;

    // In IDLE the first byte is looked up straight from the inputs being latched
    assign code_sel   = (state == ST_IDLE) ? msg_code : code_q;
    assign cur_sel    = (state == ST_IDLE) ? currency : cur_q;
    assign val_sel    = (state == ST_IDLE) ? value    : val_q;
    assign nibble_sel = val_sel[{nxt_idx, 2'b00} +: 4];

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        case (state)
            ST_IDLE: begin
                nxt_state = ST_PREFIX;
                nxt_idx   = 2'd0;
            end
            ST_PREFIX: begin
                if (idx == 2'd3) begin
                    nxt_state = show_q ? ST_SEP1 : ST_CR;
                    nxt_idx   = 2'd0;
                end else begin
                    nxt_idx = idx + 2'd1;
                end
            end
            ST_SEP1: begin
                nxt_state = ST_CUR;
                nxt_idx   = 2'd0;
            end
            ST_CUR: begin
                if (idx == 2'd2) begin
                    nxt_state = ST_SEP2;
                    nxt_idx   = 2'd0;
                end else begin
                    nxt_idx = idx + 2'd1;
                end
            end
            ST_SEP2: begin
                nxt_state = ST_DIGITS;
                nxt_idx   = 2'd0;
            end
            ST_DIGITS: begin
                if (idx == 2'd3) begin
                    nxt_state = ST_CR;
                    nxt_idx   = 2'd0;
                end else begin
                    nxt_idx = idx + 2'd1;
                end
            end
            ST_CR:   nxt_state = EOL_LF ? ST_LF : ST_IDLE;
            ST_LF:   nxt_state = ST_IDLE;
            default: nxt_state = ST_IDLE;
        endcase
    end

    msg_char_rom u_rom (
        .state    (nxt_state),
        .idx      (nxt_idx),
        .code     (code_sel),
        .currency (cur_sel),
        .nibble   (nibble_sel),
        .char_out (rom_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= 2'd0;
            code_q   <= 4'd0;
            show_q   <= 1'b0;
            cur_q    <= 3'd0;
            val_q    <= 16'd0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    code_q   <= msg_code;
                    show_q   <= show_value;
                    cur_q    <= currency;
                    val_q    <= value;
                    state    <= nxt_state;
                    idx      <= nxt_idx;
                    tx_data  <= rom_byte;
                    tx_valid <= 1'b1;
                    busy     <= 1'b1;
                end
            end else if (abort) begin
                state    <= ST_IDLE;
                idx      <= 2'd0;
                tx_valid <= 1'b0;
                busy     <= 1'b0;
            end else if (xfer) begin
                state <= nxt_state;
                idx   <= nxt_idx;
                if (nxt_state == ST_IDLE) begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    tx_data <= rom_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_atm_message_tx.sv
// Bench for atm_message_tx: table of messages with hand-written text, run with
// and without backpressure, plus abort, ignored start, reset and CR-only cases.
module tb_atm_message_tx;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  msg_code;
    logic        show_value;
    logic [2:0]  currency;
    logic [15:0] value;
    logic        abort;
    logic        tx_ready;
    logic [7:0]  tx_data,  tx_data_cr;
    logic        tx_valid, tx_valid_cr;
    logic        busy,     busy_cr;
    logic        done,     done_cr;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [3:0]      code;
        logic            show;
        logic [2:0]      cur;
        logic [15:0]     val;
        logic [8*13-1:0] text;
        int              tlen;
    } vec_t;

    vec_t vecs[11];

    atm_message_tx #(.EOL_LF(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .msg_code(msg_code),
        .show_value(show_value), .currency(currency), .value(value), .abort(abort),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    atm_message_tx #(.EOL_LF(1'b0)) u_dut_cr (
        .clk(clk), .rst_n(rst_n), .start(start), .msg_code(msg_code),
        .show_value(show_value), .currency(currency), .value(value), .abort(abort),
        .tx_data(tx_data_cr), .tx_valid(tx_valid_cr), .tx_ready(tx_ready),
        .busy(busy_cr), .done(done_cr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver + scoreboard for one message on the LF-terminated instance
    task automatic run_msg(input vec_t v, input bit bp, input int pulse_start_at);
        int cyc;
        bit got_done;
        bit prev_stall;
        logic [7:0] prev_data;
        int n;
        exp_q.delete();
        for (int i = 0; i < v.tlen; i++) exp_q.push_back(v.text[(v.tlen-1-i)*8 +: 8]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        n = exp_q.size();
        @(negedge clk);
        msg_code = v.code; show_value = v.show; currency = v.cur; value = v.val;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        msg_code = 4'($urandom_range(0, 15));
        show_value = ~v.show;
        currency = 3'($urandom_range(0, 7));
        value = 16'($urandom_range(0, 65535));
        cyc = 1; got_done = 0; prev_stall = 0; prev_data = 8'h00;
        while (!got_done && cyc < 300) begin
            start = (cyc == pulse_start_at);
            tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done) begin
                got_done = 1;
                if (!bp) check("done_cycle", cyc, n + 1);
                check("done_busy", {31'd0, busy}, 0);
                check("done_valid", {31'd0, tx_valid}, 0);
                check("all_bytes_sent", exp_q.size(), 0);
            end else begin
                check("valid_in_msg", {31'd0, tx_valid}, 1);
                check("busy_in_msg", {31'd0, busy}, 1);
                if (prev_stall) check("stall_stable", {24'd0, tx_data}, {24'd0, prev_data});
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) check("extra_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
                    else check("byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        if (!got_done) check("done_timeout", 0, 1);
        tx_ready = 1'b1;
    endtask

    initial begin
        int cyc;
        logic [7:0] cr_q[$];
        int cr_cnt;
        bit cr_done;

        vecs[0]  = '{4'd3, 1'b0, 3'd0, 16'h0000, "PNOK", 4};
        vecs[1]  = '{4'd5, 1'b1, 3'd1, 16'h4321, "AMOK BTC 1234", 13};
        vecs[2]  = '{4'd0, 1'b1, 3'd6, 16'h00A9, "ERR? ??? 9?00", 13};
        vecs[3]  = '{4'd7, 1'b1, 3'd0, 16'h9876, "EXIT USD 6789", 13};
        vecs[4]  = '{4'd8, 1'b0, 3'd2, 16'h5555, "DONE", 4};
        vecs[5]  = '{4'd2, 1'b1, 3'd4, 16'h0000, "ACNF LTC 0000", 13};
        vecs[6]  = '{4'd1, 1'b0, 3'd0, 16'h0000, "ACOK", 4};
        vecs[7]  = '{4'd4, 1'b0, 3'd0, 16'h0000, "PNBD", 4};
        vecs[8]  = '{4'd6, 1'b1, 3'd2, 16'hF005, "AMBD ETH 500?", 13};
        vecs[9]  = '{4'd9, 1'b0, 3'd0, 16'h0000, "ERR?", 4};
        vecs[10] = '{4'd1, 1'b1, 3'd3, 16'h1111, "ACOK XRP 1111", 13};

        rst_n = 1'b0; start = 1'b0; msg_code = 4'd0; show_value = 1'b0;
        currency = 3'd0; value = 16'd0; abort = 1'b0; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, tx_data}, 0);
        check("rst_valid", {31'd0, tx_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_msg(vecs[i], 1'b0, -1);
        for (int i = 0; i < 11; i++) run_msg(vecs[i], 1'b1, -1);

        // start pulsed mid-message must not queue a second message
        run_msg(vecs[1], 1'b0, 4);
        repeat (5) begin
            @(negedge clk);
            check("no_extra_msg", {31'd0, tx_valid}, 0);
        end

        // abort on edge 3 of a 15-byte message
        @(negedge clk);
        msg_code = 4'd5; show_value = 1'b1; currency = 3'd1; value = 16'h4321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", {31'd0, tx_valid}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        repeat (20) begin
            check("abort_no_done", {31'd0, done}, 0);
            @(negedge clk);
        end

        // abort in idle is ignored; start with abort on the same edge starts
        abort = 1'b1;
        @(negedge clk);
        check("idle_abort_valid", {31'd0, tx_valid}, 0);
        msg_code = 4'd8; show_value = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_valid", {31'd0, tx_valid}, 1);
        check("start_abort_data", {24'd0, tx_data}, 32'h44);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("kill_valid", {31'd0, tx_valid}, 0);

        // asynchronous reset mid-message
        @(negedge clk);
        msg_code = 4'd5; show_value = 1'b1; currency = 3'd1; value = 16'h4321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_data", {24'd0, tx_data}, 0);
        check("arst_valid", {31'd0, tx_valid}, 0);
        check("arst_busy", {31'd0, busy}, 0);
        check("arst_done", {31'd0, done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_msg(vecs[1], 1'b0, -1);
        run_msg(vecs[2], 1'b1, -1);

        // CR-only instance: "ACOK\r", 5 bytes, done in cycle 6
        cr_q.delete();
        cr_q.push_back(8'h41); cr_q.push_back(8'h43); cr_q.push_back(8'h4F);
        cr_q.push_back(8'h4B); cr_q.push_back(8'h0D);
        @(negedge clk);
        msg_code = 4'd1; show_value = 1'b0; start = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; cr_cnt = 0; cr_done = 0;
        while (!cr_done && cyc < 50) begin
            if (done_cr) begin
                cr_done = 1;
                check("cr_done_cycle", cyc, 6);
                check("cr_byte_count", cr_cnt, 5);
                check("cr_valid_end", {31'd0, tx_valid_cr}, 0);
            end else begin
                if (tx_valid_cr) begin
                    cr_cnt++;
                    if (cr_q.size() == 0) check("cr_extra_byte", {24'd0, tx_data_cr}, 32'hFFFF_FFFF);
                    else check("cr_byte", {24'd0, tx_data_cr}, {24'd0, cr_q.pop_front()});
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!cr_done) check("cr_done_timeout", 0, 1);
        repeat (4) @(negedge clk);
        check("end_idle", {31'd0, busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
